// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker
//
// Multi-channel colour-blob tracker. Each pixel is classified against NUM_CH
// colour rules. Every matching pixel updates that channel's count, coordinate
// sums and bounding box. On frame_start the totals are snapshotted and the
// accumulators restart. One shared restoring divider then computes all 2*NUM_CH
// centroid coordinates. The full result set is published in one cycle.
//
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   pixel           {R[17:12], G[11:6], B[5:0]}; only the top 5 bits of each field are used
//   x, y            pixel coordinates, qualified by pixel_valid
//   pixel_valid     pixel/x/y are valid this cycle
//   frame_start     pulse on the first pixel of a frame
//   ch_sel          per channel 2 bits: 0=R, 1=G, 2=B, 3=disabled
//   ch_min, ch_diff per channel 5 bits: main-colour floor, margin over the others
//   min_count       minimum pixel count for a channel to be reported as found
//   included        combinational per-channel classification of the current pixel
//   x_center, y_center, count, bbox, found   published results (bbox = {xmin,xmax,ymin,ymax})
//   result_valid    one-cycle pulse in the cycle the results update
//   busy            divider running
//   overrun         one-cycle pulse when a frame snapshot had to be dropped
module color_centroid_tracker #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned X_W    = 11,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned CNT_W  = 20,
    parameter int unsigned X_DEF  = 360,
    parameter int unsigned Y_DEF  = 240
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [17:0]                       pixel,
    input  logic [X_W-1:0]                    x,
    input  logic [Y_W-1:0]                    y,
    input  logic                              pixel_valid,
    input  logic                              frame_start,
    input  logic [2*NUM_CH-1:0]               ch_sel,
    input  logic [5*NUM_CH-1:0]               ch_min,
    input  logic [5*NUM_CH-1:0]               ch_diff,
    input  logic [CNT_W-1:0]                  min_count,
    output logic [NUM_CH-1:0]                 included,
    output logic [X_W*NUM_CH-1:0]             x_center,
    output logic [Y_W*NUM_CH-1:0]             y_center,
    output logic [CNT_W*NUM_CH-1:0]           count,
    output logic [2*(X_W+Y_W)*NUM_CH-1:0]     bbox,
    output logic [NUM_CH-1:0]                 found,
    output logic                              result_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int unsigned XS_W  = X_W + CNT_W;
    localparam int unsigned YS_W  = Y_W + CNT_W;
    localparam int unsigned DIV_W = ((X_W > Y_W) ? X_W : Y_W) + CNT_W;
    localparam int unsigned BIT_W = $clog2(DIV_W);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = CH_W + 1;
    localparam int unsigned BB_W  = 2 * (X_W + Y_W);

    typedef enum logic [1:0] {StIdle, StDiv, StPublish} state_e;

    state_e state_q, state_d;

    // ---------------- classification ----------------
    logic [4:0] r5, g5, b5;
    logic [4:0] main_f [NUM_CH];
    logic [4:0] oth1_f [NUM_CH];
    logic [4:0] oth2_f [NUM_CH];
    logic       unused_pixel;

    assign r5 = pixel[17:13];
    assign g5 = pixel[11:7];
    assign b5 = pixel[5:1];
    assign unused_pixel = ^{pixel[12], pixel[6], pixel[0]};

    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            case (ch_sel[2*c +: 2])
                2'd0:    begin main_f[c] = r5; oth1_f[c] = g5; oth2_f[c] = b5; end
                2'd1:    begin main_f[c] = g5; oth1_f[c] = r5; oth2_f[c] = b5; end
                default: begin main_f[c] = b5; oth1_f[c] = r5; oth2_f[c] = g5; end
            endcase
            // Subtractions are only meaningful once main exceeds both others,
            // which the preceding terms guarantee.
            included[c] = pixel_valid && (ch_sel[2*c +: 2] != 2'd3)
                        && (main_f[c] > ch_min[5*c +: 5])
                        && (main_f[c] > oth1_f[c]) && (main_f[c] > oth2_f[c])
                        && ((main_f[c] - oth1_f[c]) > ch_diff[5*c +: 5])
                        && ((main_f[c] - oth2_f[c]) > ch_diff[5*c +: 5]);
        end
    end

    // ---------------- accumulators ----------------
    logic [CNT_W-1:0] cnt_q  [NUM_CH], cnt_d  [NUM_CH];
    logic [XS_W-1:0]  xsum_q [NUM_CH], xsum_d [NUM_CH];
    logic [YS_W-1:0]  ysum_q [NUM_CH], ysum_d [NUM_CH];
    logic [X_W-1:0]   xmin_q [NUM_CH], xmin_d [NUM_CH];
    logic [X_W-1:0]   xmax_q [NUM_CH], xmax_d [NUM_CH];
    logic [Y_W-1:0]   ymin_q [NUM_CH], ymin_d [NUM_CH];
    logic [Y_W-1:0]   ymax_q [NUM_CH], ymax_d [NUM_CH];

    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            // frame_start clears first so the same-cycle pixel seeds the new frame
            cnt_d[c]  = frame_start ? '0 : cnt_q[c];
            xsum_d[c] = frame_start ? '0 : xsum_q[c];
            ysum_d[c] = frame_start ? '0 : ysum_q[c];
            xmin_d[c] = frame_start ? '1 : xmin_q[c];
            xmax_d[c] = frame_start ? '0 : xmax_q[c];
            ymin_d[c] = frame_start ? '1 : ymin_q[c];
            ymax_d[c] = frame_start ? '0 : ymax_q[c];
            if (included[c]) begin
                cnt_d[c]  = cnt_d[c] + CNT_W'(1);
                xsum_d[c] = xsum_d[c] + XS_W'(x);
                ysum_d[c] = ysum_d[c] + YS_W'(y);
                if (x < xmin_d[c]) xmin_d[c] = x;
                if (x > xmax_d[c]) xmax_d[c] = x;
                if (y < ymin_d[c]) ymin_d[c] = y;
                if (y > ymax_d[c]) ymax_d[c] = y;
            end
        end
    end

    // ---------------- snapshot bank ----------------
    logic [CNT_W-1:0] snap_cnt  [NUM_CH];
    logic [XS_W-1:0]  snap_xsum [NUM_CH];
    logic [YS_W-1:0]  snap_ysum [NUM_CH];
    logic [X_W-1:0]   snap_xmin [NUM_CH];
    logic [X_W-1:0]   snap_xmax [NUM_CH];
    logic [Y_W-1:0]   snap_ymin [NUM_CH];
    logic [Y_W-1:0]   snap_ymax [NUM_CH];

    // A snapshot is only taken when the divider is not using the bank.
    logic accept;
    assign accept = frame_start && (state_q != StDiv);

    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (reset) begin
                cnt_q[c]     <= '0;
                xsum_q[c]    <= '0;
                ysum_q[c]    <= '0;
                xmin_q[c]    <= '1;
                xmax_q[c]    <= '0;
                ymin_q[c]    <= '1;
                ymax_q[c]    <= '0;
                snap_cnt[c]  <= '0;
                snap_xsum[c] <= '0;
                snap_ysum[c] <= '0;
                snap_xmin[c] <= '1;
                snap_xmax[c] <= '0;
                snap_ymin[c] <= '1;
                snap_ymax[c] <= '0;
            end else begin
                cnt_q[c]  <= cnt_d[c];
                xsum_q[c] <= xsum_d[c];
                ysum_q[c] <= ysum_d[c];
                xmin_q[c] <= xmin_d[c];
                xmax_q[c] <= xmax_d[c];
                ymin_q[c] <= ymin_d[c];
                ymax_q[c] <= ymax_d[c];
                if (accept) begin
                    snap_cnt[c]  <= cnt_q[c];
                    snap_xsum[c] <= xsum_q[c];
                    snap_ysum[c] <= ysum_q[c];
                    snap_xmin[c] <= xmin_q[c];
                    snap_xmax[c] <= xmax_q[c];
                    snap_ymin[c] <= ymin_q[c];
                    snap_ymax[c] <= ymax_q[c];
                end
            end
        end
    end

    // ---------------- shared serial divider ----------------
    // Division index order: ch0 x, ch0 y, ch1 x, ... (LSB selects y).
    logic [DIV_W-1:0] quo_q, quo_nx, next_dividend;
    logic [CNT_W-1:0] rem_q, rem_nx, divisor;
    logic [CNT_W:0]   rem_sh, rem_sub;
    logic             rem_ge, unused_rem;
    logic [BIT_W-1:0] bit_q;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [CH_W-1:0]  div_ch, nx_ch;
    logic             bit_end, last_step;

    assign div_ch    = idx_q[IDX_W-1:1];
    assign idx_nx    = idx_q + IDX_W'(1);
    assign nx_ch     = idx_nx[IDX_W-1:1];
    assign divisor   = snap_cnt[div_ch];
    assign bit_end   = (state_q == StDiv) && (bit_q == BIT_W'(DIV_W - 1));
    assign last_step = bit_end && (idx_q == IDX_W'(2 * NUM_CH - 1));

    always_comb begin
        rem_sh        = {rem_q, quo_q[DIV_W-1]};
        rem_ge        = rem_sh >= {1'b0, divisor};
        rem_sub       = rem_sh - {1'b0, divisor};
        rem_nx        = rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quo_nx        = {quo_q[DIV_W-2:0], rem_ge};
        next_dividend = idx_nx[0] ? DIV_W'(snap_ysum[nx_ch]) : DIV_W'(snap_xsum[nx_ch]);
    end
    assign unused_rem = rem_sub[CNT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            bit_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            // The bank loads on this same edge, so take ch0 x straight from the accumulator.
            quo_q <= DIV_W'(xsum_q[0]);
            rem_q <= '0;
            bit_q <= '0;
            idx_q <= '0;
        end else if (state_q == StDiv) begin
            if (bit_end) begin
                quo_q <= next_dividend;
                rem_q <= '0;
                bit_q <= '0;
                idx_q <= idx_nx;
            end else begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                bit_q <= bit_q + BIT_W'(1);
            end
        end
    end

    // Quotient staging; the _d view includes the quotient finishing this cycle so the
    // final division can be published on the same edge.
    logic [X_W-1:0] xq_q [NUM_CH], xq_d [NUM_CH];
    logic [Y_W-1:0] yq_q [NUM_CH], yq_d [NUM_CH];

    always_comb begin
        xq_d = xq_q;
        yq_d = yq_q;
        if (bit_end) begin
            if (idx_q[0]) yq_d[div_ch] = quo_nx[Y_W-1:0];
            else          xq_d[div_ch] = quo_nx[X_W-1:0];
        end
    end

    // ---------------- published outputs ----------------
    logic [X_W-1:0]   xc_q   [NUM_CH];
    logic [Y_W-1:0]   yc_q   [NUM_CH];
    logic [CNT_W-1:0] cnto_q [NUM_CH];
    logic [BB_W-1:0]  bb_q   [NUM_CH];
    logic [NUM_CH-1:0] found_q;
    logic              overrun_q;
    logic              ok [NUM_CH];

    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            ok[c] = (snap_cnt[c] != '0) && (snap_cnt[c] >= min_count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            found_q   <= '0;
            overrun_q <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                xq_q[c]   <= '0;
                yq_q[c]   <= '0;
                xc_q[c]   <= X_W'(X_DEF);
                yc_q[c]   <= Y_W'(Y_DEF);
                cnto_q[c] <= '0;
                bb_q[c]   <= {{X_W{1'b1}}, {X_W{1'b0}}, {Y_W{1'b1}}, {Y_W{1'b0}}};
            end
        end else begin
            overrun_q <= frame_start && (state_q == StDiv);
            for (int c = 0; c < int'(NUM_CH); c++) begin
                xq_q[c] <= xq_d[c];
                yq_q[c] <= yq_d[c];
                if (last_step) begin
                    xc_q[c]    <= ok[c] ? xq_d[c] : X_W'(X_DEF);
                    yc_q[c]    <= ok[c] ? yq_d[c] : Y_W'(Y_DEF);
                    cnto_q[c]  <= snap_cnt[c];
                    bb_q[c]    <= {snap_xmin[c], snap_xmax[c], snap_ymin[c], snap_ymax[c]};
                    found_q[c] <= ok[c];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign x_center[c*X_W +: X_W]     = xc_q[c];
        assign y_center[c*Y_W +: Y_W]     = yc_q[c];
        assign count[c*CNT_W +: CNT_W]    = cnto_q[c];
        assign bbox[c*BB_W +: BB_W]       = bb_q[c];
    end
    assign found   = found_q;
    assign overrun = overrun_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (frame_start) state_d = StDiv;
            StDiv:     if (last_step)   state_d = StPublish;
            StPublish: state_d = frame_start ? StDiv : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q == StDiv);
        result_valid = (state_q == StPublish);
    end

endmodule

// File: tb/tb_color_centroid_tracker.sv
module tb_color_centroid_tracker;

    localparam int NUM_CH = 2;
    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int CNT_W  = 20;
    localparam int BB_W   = 2 * (X_W + Y_W);
    localparam int LAT    = 125;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [17:0]                   pixel;
    logic [X_W-1:0]                x;
    logic [Y_W-1:0]                y;
    logic                          pixel_valid;
    logic                          frame_start;
    logic [2*NUM_CH-1:0]           ch_sel;
    logic [5*NUM_CH-1:0]           ch_min;
    logic [5*NUM_CH-1:0]           ch_diff;
    logic [CNT_W-1:0]              min_count;
    logic [NUM_CH-1:0]             included;
    logic [X_W*NUM_CH-1:0]         x_center;
    logic [Y_W*NUM_CH-1:0]         y_center;
    logic [CNT_W*NUM_CH-1:0]       count;
    logic [BB_W*NUM_CH-1:0]        bbox;
    logic [NUM_CH-1:0]             found;
    logic                          result_valid;
    logic                          busy;
    logic                          overrun;

    color_centroid_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .pixel        (pixel),
        .x            (x),
        .y            (y),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .ch_sel       (ch_sel),
        .ch_min       (ch_min),
        .ch_diff      (ch_diff),
        .min_count    (min_count),
        .included     (included),
        .x_center     (x_center),
        .y_center     (y_center),
        .count        (count),
        .bbox         (bbox),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [17:0] pix;
        logic        pv;
        logic [1:0]  sel;
        logic [4:0]  mn;
        logic [4:0]  df;
        logic        exp_inc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] rgb(input int r6, input int g6, input int b6);
        logic [5:0] r, g, b;
        r = 6'(r6); g = 6'(g6); b = 6'(b6);
        return {r, g, b};
    endfunction

    function automatic logic [BB_W-1:0] bb(input int xmn, input int xmx, input int ymn, input int ymx);
        logic [X_W-1:0] a, b;
        logic [Y_W-1:0] c, d;
        a = X_W'(xmn); b = X_W'(xmx); c = Y_W'(ymn); d = Y_W'(ymx);
        return {a, b, c, d};
    endfunction

    task automatic put_pix(input logic [17:0] p, input int xx, input int yy);
        pixel = p; x = X_W'(xx); y = Y_W'(yy); pixel_valid = 1'b1;
        tick();
    endtask

    // Called in the cycle where frame_start is asserted; returns in the PUBLISH cycle.
    task automatic run_to_result(input string name, output int lat);
        lat = 0;
        do begin
            tick();
            frame_start = 1'b0;
            pixel_valid = 1'b0;
            lat++;
            if (lat == 1) check({name, " busy at T+1"}, 64'(busy), 64'd1);
        end while (!result_valid && lat < 300);
    endtask

    task automatic check_ch(input string name, input int c, input int cnt, input int xc,
                            input int yc, input logic [BB_W-1:0] bbe, input int fnd);
        check({name, " count"},    64'(count[c*CNT_W +: CNT_W]), 64'(cnt));
        check({name, " x_center"}, 64'(x_center[c*X_W +: X_W]),  64'(xc));
        check({name, " y_center"}, 64'(y_center[c*Y_W +: Y_W]),  64'(yc));
        check({name, " bbox"},     64'(bbox[c*BB_W +: BB_W]),     64'(bbe));
        check({name, " found"},    64'(found[c]),                 64'(fnd));
    endtask

    vec_t tbl[13];

    initial begin
        int lat;
        int k;
        int ovr_cnt;
        int ovr_at;

        tbl[0]  = '{rgb(63, 0, 0),  1'b1, 2'd0, 5'd10, 5'd4, 1'b1};
        tbl[1]  = '{rgb(40, 32, 0), 1'b1, 2'd0, 5'd10, 5'd4, 1'b0}; // margin == diff
        tbl[2]  = '{rgb(40, 30, 0), 1'b1, 2'd0, 5'd10, 5'd4, 1'b1};
        tbl[3]  = '{rgb(41, 31, 0), 1'b1, 2'd0, 5'd10, 5'd4, 1'b1}; // field LSBs ignored
        tbl[4]  = '{rgb(20, 0, 0),  1'b1, 2'd0, 5'd10, 5'd4, 1'b0}; // main == ch_min
        tbl[5]  = '{rgb(22, 0, 0),  1'b1, 2'd0, 5'd10, 5'd4, 1'b1};
        tbl[6]  = '{rgb(0, 63, 0),  1'b1, 2'd1, 5'd10, 5'd4, 1'b1};
        tbl[7]  = '{rgb(63, 0, 0),  1'b1, 2'd2, 5'd10, 5'd4, 1'b0};
        tbl[8]  = '{rgb(63, 0, 0),  1'b1, 2'd3, 5'd10, 5'd4, 1'b0};
        tbl[9]  = '{rgb(63, 63, 63),1'b1, 2'd0, 5'd10, 5'd4, 1'b0};
        tbl[10] = '{rgb(63, 0, 0),  1'b0, 2'd0, 5'd10, 5'd4, 1'b0};
        tbl[11] = '{rgb(0, 0, 63),  1'b1, 2'd2, 5'd10, 5'd4, 1'b1};
        tbl[12] = '{rgb(40, 0, 32), 1'b1, 2'd0, 5'd10, 5'd4, 1'b0}; // margin over B == diff

        reset = 1'b1; pixel = '0; x = '0; y = '0; pixel_valid = 1'b0; frame_start = 1'b0;
        ch_sel = '1; ch_min = '0; ch_diff = '0; min_count = CNT_W'(2);

        // Classification is combinational; apply the table while reset holds the accumulators.
        for (int i = 0; i < 13; i++) begin
            ch_sel      = {2'd3, tbl[i].sel};
            ch_min      = {5'd0, tbl[i].mn};
            ch_diff     = {5'd0, tbl[i].df};
            pixel       = tbl[i].pix;
            pixel_valid = tbl[i].pv;
            #1;
            check($sformatf("class vec%0d", i), 64'(included), 64'({1'b0, tbl[i].exp_inc}));
            #1;
        end
        pixel_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset x_center", 64'(x_center), 64'({11'd360, 11'd360}));
        check("reset y_center", 64'(y_center), 64'({10'd240, 10'd240}));
        check("reset count",    64'(count), 64'd0);
        check("reset bbox ch0", 64'(bbox[0 +: BB_W]), 64'(bb(2047, 0, 1023, 0)));
        check("reset bbox ch1", 64'(bbox[BB_W +: BB_W]), 64'(bb(2047, 0, 1023, 0)));
        check("reset flags",    64'({found, result_valid, busy, overrun}), 64'd0);

        // Frame 1: red 10x10 square on ch0, single green pixel on ch1.
        ch_sel = {2'd1, 2'd0}; ch_min = {5'd10, 5'd10}; ch_diff = {5'd4, 5'd4};
        min_count = CNT_W'(2);
        for (int yy = 50; yy < 60; yy++)
            for (int xx = 100; xx < 110; xx++)
                put_pix(rgb(63, 0, 0), xx, yy);
        put_pix(rgb(0, 63, 0), 7, 3);
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        run_to_result("f1", lat);
        check("f1 latency", 64'(lat), 64'(LAT));
        check("f1 busy at publish", 64'(busy), 64'd0);
        check_ch("f1 ch0", 0, 100, 104, 54, bb(100, 109, 50, 59), 1);
        check_ch("f1 ch1", 1, 1, 360, 240, bb(7, 7, 3, 3), 0);
        tick();
        check("f1 result_valid pulse", 64'(result_valid), 64'd0);
        check("f1 x_center held", 64'(x_center[0 +: X_W]), 64'd104);

        // Frame A, then frame B start (seeded), then a second frame_start 50 cycles later.
        put_pix(rgb(63, 0, 0), 10, 20);
        put_pix(rgb(63, 0, 0), 12, 20);
        put_pix(rgb(63, 0, 0), 10, 22);
        put_pix(rgb(63, 0, 0), 12, 22);
        pixel = rgb(63, 0, 0); x = X_W'(200); y = Y_W'(100); pixel_valid = 1'b1;
        frame_start = 1'b1;
        k = 0; ovr_cnt = 0; ovr_at = -1;
        do begin
            tick();
            k++;
            if (overrun) begin ovr_cnt++; ovr_at = k; end
            frame_start = (k == 50);
            pixel_valid = 1'b0;
            if (k == 1)  begin pixel_valid = 1'b1; x = X_W'(202); y = Y_W'(100); end
            if (k == 52) begin pixel_valid = 1'b1; x = X_W'(300); y = Y_W'(150); end
            if (k == 53) begin pixel_valid = 1'b1; x = X_W'(302); y = Y_W'(152); end
        end while (!result_valid && k < 300);
        frame_start = 1'b0; pixel_valid = 1'b0;
        check("ovr latency", 64'(k), 64'(LAT));
        check("ovr pulse count", 64'(ovr_cnt), 64'd1);
        check("ovr pulse cycle", 64'(ovr_at), 64'd51);
        check_ch("ovr ch0", 0, 4, 11, 21, bb(10, 12, 20, 22), 1);
        check_ch("ovr ch1", 1, 0, 360, 240, bb(2047, 0, 1023, 0), 0);

        // Frame C accumulated from the second frame_start only.
        repeat (3) tick();
        frame_start = 1'b1;
        run_to_result("fc", lat);
        check("fc latency", 64'(lat), 64'(LAT));
        check_ch("fc ch0", 0, 2, 301, 151, bb(300, 302, 150, 152), 1);

        // All channels disabled with white input.
        tick();
        ch_sel = '1;
        for (int i = 0; i < 4; i++) begin
            pixel = rgb(63, 63, 63); x = X_W'(50 + i); y = Y_W'(60); pixel_valid = 1'b1;
            #1;
            check($sformatf("disabled included %0d", i), 64'(included), 64'd0);
            tick();
        end
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        run_to_result("dis", lat);
        check("dis latency", 64'(lat), 64'(LAT));
        check("dis found", 64'(found), 64'd0);
        check("dis count", 64'(count), 64'd0);
        check("dis x_center", 64'(x_center), 64'({11'd360, 11'd360}));

        // frame_start coinciding with PUBLISH is accepted without overrun.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pub+fs overrun", 64'(overrun), 64'd0);
        check("pub+fs busy", 64'(busy), 64'd1);
        run_to_result("pub+fs", lat);
        check("pub+fs latency", 64'(lat), 64'(LAT - 1));
        check("pub+fs found", 64'(found), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
